instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V core. It holds the PC, issues word reads to instruction memory over a request/grant interface, and buffers returned instructions in a small FIFO. It presents each instruction, with its PC and opcode field, to the decode stage (main decoder) through a valid/ready handshake. It accepts redirects from branch/jump resolution and discards responses made stale by a redirect.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 143 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: datapath width, major opcodes and the
// fetch-stage buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    // Major opcode field values (instr[6:0]) seen by the main decoder.
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // One instruction-buffer entry: the fetched word and the PC it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } FetchEntry;

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with single-cycle flush. The head entry is shown
// combinationally from storage, so it stays put until it is popped.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        pushData,
    input  logic                    pop,
    output logic [WIDTH-1:0]        headData,
    output logic [$clog2(DEPTH):0]  occ,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;

    // Pointer and occupancy tracking; flush empties the queue in one cycle.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    // Entry storage; cleared on reset so the head reads as zero afterwards.
    // NOTE: the array is reset deliberately -- the head is visible on the
    // outputs, and reset must present all-zero instruction and PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wrPtr] <= pushData;
        end
    end

    assign headData = mem[rdPtr];
    assign occ      = count;
    assign empty    = (count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over a
// request/grant bus, buffers in-order responses and hands them to decode.
// Redirects flush the buffer and mark every in-flight response as stale.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_CNT = (CNT_W+1)'(DEPTH);

    logic [XLEN-1:0]  pc;
    logic [CNT_W-1:0] stale;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W:0]   inUse;

    logic             fifoEmpty;
    logic             pcqEmpty;
    logic [63:0]      fifoHead;
    logic [XLEN-1:0]  pcqHead;
    FetchEntry        pushEntry;
    FetchEntry        headEntry;

    logic             grant;
    logic             rspHit;
    logic             fifoPush;
    logic             fifoPop;

    // Issue, response-acceptance and pop decisions from registered counts.
    // NOTE: every signal written here gets a default first so no path through
    // the block leaves one unassigned and a latch cannot be inferred.
    always_comb begin
        inUse       = {1'b0, occ} + {1'b0, outstanding};
        imem_req    = 1'b0;
        grant       = 1'b0;
        rspHit      = 1'b0;
        fifoPush    = 1'b0;
        instr_valid = 1'b0;
        fifoPop     = 1'b0;
        pushEntry   = '{instr: imem_rdata, pc: pcqHead};

        // Only issue when a buffer slot is guaranteed for the response.
        imem_req = !rst && !redirect_valid && (inUse < DEPTH_CNT);
        grant    = imem_req && imem_gnt;

        // A response with nothing in flight is spurious and ignored.
        rspHit   = imem_rvalid && !pcqEmpty;

        // Stale responses and any response landing on a redirect are dropped.
        fifoPush = rspHit && !redirect_valid && (stale == '0);

        instr_valid = !fifoEmpty && !redirect_valid;
        fifoPop     = instr_valid && instr_ready;
    end

    // Fetch PC and count of in-flight responses to discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            stale <= '0;
        end else if (redirect_valid) begin
            pc    <= wordAlign(redirect_pc);
            // Everything still in flight now belongs to the old path. The
            // stale responses are already part of that in-flight total, so
            // the new count is the total minus any response retiring now.
            stale <= outstanding - CNT_W'(rspHit);
        end else begin
            if (grant) begin
                pc <= pc + 32'd4;
            end
            if (rspHit && (stale != '0)) begin
                stale <= stale - CNT_W'(1);
            end
        end
    end

    // Instruction buffer of {instr, pc}, emptied by a redirect.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_instrBuf (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .push     (fifoPush),
        .pushData (pushEntry),
        .pop      (fifoPop),
        .headData (fifoHead),
        .occ      (occ),
        .empty    (fifoEmpty)
    );

    // In-order PCs of granted requests. Not flushed on redirect: each
    // in-flight response, stale or not, still retires its entry, so the
    // occupancy is exactly the outstanding-request count.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pcQueue (
        .clk      (clk),
        .rst      (rst),
        .flush    (1'b0),
        .push     (grant),
        .pushData (pc),
        .pop      (rspHit),
        .headData (pcqHead),
        .occ      (outstanding),
        .empty    (pcqEmpty)
    );

    assign headEntry = FetchEntry'(fifoHead);
    assign imem_addr = pc;
    assign instr     = headEntry.instr;
    assign instr_pc  = headEntry.pc;
    assign op        = headEntry.instr[6:0];

    // Buffered plus in-flight never exceeds DEPTH, so a response always fits.
    assertSlotBound : assert property (@(posedge clk) disable iff (rst)
        inUse <= DEPTH_CNT);

    // Stale responses are a subset of those in flight.
    assertStaleBound : assert property (@(posedge clk) disable iff (rst)
        stale <= outstanding);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios with a behavioural
// instruction memory; expected {pc, instr} pairs are queued by the stimulus
// and consumed by an independent monitor on each decode handshake.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  op;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int tests = 0;
    int fails = 0;

    typedef struct { logic [31:0] pc; logic [31:0] instr; } ExpItem;
    typedef struct { int due; logic [31:0] addr; } Pending;

    ExpItem      sbQ[$];
    Pending      pend[$];
    logic [31:0] grantLog[$];
    int          cyc = 0;
    int          memLat = 1;
    int          spuriousCycle = -1;

    instr_fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .op             (op),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed function of the word address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[24:0], OP_ITYPE};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expectPc(input logic [31:0] pc);
        sbQ.push_back('{pc: pc, instr: memWord(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic atNeg();
        @(negedge clk);
    endtask

    task automatic drain(input string name, input int n);
        repeat (n) step();
        atNeg();
        check({name, "_drained"}, sbQ.size(), 0);
        step();
    endtask

    task automatic applyReset();
        rst = 1'b1;
        imem_gnt = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        step();
        step();
        sbQ.delete();
        grantLog.delete();
        rst = 1'b0;
    endtask

    // Memory model: grants sampled mid-cycle, in-order responses after memLat cycles.
    always begin
        @(negedge clk);
        if (rst) begin
            pend.delete();
        end else if (imem_req && imem_gnt) begin
            pend.push_back('{due: cyc + memLat, addr: imem_addr});
            grantLog.push_back(imem_addr);
        end
        @(posedge clk);
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (!rst) begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(pend[0].addr);
                void'(pend.pop_front());
            end else if (cyc == spuriousCycle) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: each accepted instruction is compared with the queue head.
    always @(negedge clk) begin : monitor
        ExpItem e;
        if (!rst && instr_valid && instr_ready) begin
            if (sbQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc %h expected none", instr_pc);
            end else begin
                e = sbQ.pop_front();
                check("sb_pc", instr_pc, e.pc);
                check("sb_instr", instr, e.instr);
                check("sb_op", {25'b0, op}, {25'b0, e.instr[6:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values and linear fetch with 1-cycle memory.
        step();
        step();
        atNeg();
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_op", {25'b0, op}, 32'h0);
        step();
        rst = 1'b0;
        memLat = 1;
        imem_gnt = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) expectPc(32'(i * 4));
        for (int k = 0; k < 8; k++) begin
            atNeg();
            if (k < 4) begin
                check("lin_req", imem_req, 1'b1);
                check("lin_addr", imem_addr, 32'(k * 4));
            end
            check("lin_valid", instr_valid, (k >= 2) ? 1'b1 : 1'b0);
            step();
            if (k == 5) imem_gnt = 1'b0;
        end
        drain("lin", 4);
        check("lin_grants", grantLog.size(), 6);
        check("lin_next_pc", imem_addr, 32'd24);

        // Decode stall: buffer fills after exactly DEPTH grants.
        applyReset();
        memLat = 1;
        imem_gnt = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) expectPc(32'(i * 4));
        for (int k = 0; k < 10; k++) begin
            atNeg();
            if (k >= 2) begin
                check("stall_valid", instr_valid, 1'b1);
                check("stall_pc", instr_pc, 32'h0);
                check("stall_instr", instr, memWord(32'h0));
            end
            step();
        end
        atNeg();
        check("stall_grants", grantLog.size(), 4);
        check("stall_req", imem_req, 1'b0);
        check("stall_addr", imem_addr, 32'd16);
        step();
        imem_gnt = 1'b0;
        instr_ready = 1'b1;
        drain("stall", 4);
        expectPc(32'd16);
        expectPc(32'd20);
        imem_gnt = 1'b1;
        step();
        step();
        imem_gnt = 1'b0;
        drain("resume", 4);
        check("resume_grants", grantLog.size(), 6);
        check("resume_addr0", grantLog[4], 32'd16);
        check("resume_addr1", grantLog[5], 32'd20);

        // Redirect with two responses in flight on 3-cycle memory.
        applyReset();
        memLat = 3;
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        step();
        step();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        atNeg();
        check("redir_req", imem_req, 1'b0);
        check("redir_valid", instr_valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        expectPc(32'h100);
        expectPc(32'h104);
        atNeg();
        check("redir_addr", imem_addr, 32'h100);
        step();
        step();
        imem_gnt = 1'b0;
        drain("redir", 10);
        check("redir_grants", grantLog.size(), 4);

        // Redirect in the same cycle as a response (unaligned target).
        applyReset();
        memLat = 1;
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        atNeg();
        check("coinc_valid", instr_valid, 1'b0);
        check("coinc_req", imem_req, 1'b0);
        step();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        expectPc(32'h200);
        atNeg();
        check("coinc_addr", imem_addr, 32'h200);
        step();
        imem_gnt = 1'b0;
        drain("coinc", 5);
        // Back-to-back redirects with nothing in flight: the last one wins.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        step();
        redirect_pc = 32'h0000_0404;
        step();
        redirect_valid = 1'b0;
        imem_gnt = 1'b1;
        expectPc(32'h404);
        atNeg();
        check("b2b_addr", imem_addr, 32'h404);
        step();
        imem_gnt = 1'b0;
        drain("b2b", 5);

        // Grant withheld, PC wrap, spurious response.
        applyReset();
        memLat = 1;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        spuriousCycle = cyc + 1;
        for (int k = 0; k < 5; k++) begin
            atNeg();
            check("hold_addr", imem_addr, 32'hFFFF_FFFC);
            check("hold_req", imem_req, 1'b1);
            check("hold_valid", instr_valid, 1'b0);
            step();
        end
        imem_gnt = 1'b1;
        expectPc(32'hFFFF_FFFC);
        expectPc(32'h0000_0000);
        atNeg();
        check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        step();
        atNeg();
        check("wrap_addr1", imem_addr, 32'h0);
        step();
        imem_gnt = 1'b0;
        atNeg();
        check("wrap_addr2", imem_addr, 32'h4);
        step();
        drain("wrap", 4);

        // Reset asserted with three buffered entries.
        applyReset();
        memLat = 1;
        instr_ready = 1'b0;
        imem_gnt = 1'b1;
        expectPc(32'h0);
        expectPc(32'h4);
        expectPc(32'h8);
        step();
        step();
        step();
        imem_gnt = 1'b0;
        step();
        atNeg();
        check("mid_valid", instr_valid, 1'b1);
        check("mid_pc", instr_pc, 32'h0);
        check("mid_addr", imem_addr, 32'd12);
        step();
        rst = 1'b1;
        #1;
        check("arst_req", imem_req, 1'b0);
        check("arst_addr", imem_addr, RESET_PC);
        check("arst_valid", instr_valid, 1'b0);
        check("arst_instr", instr, 32'h0);
        check("arst_pc", instr_pc, 32'h0);
        check("arst_op", {25'b0, op}, 32'h0);
        sbQ.delete();
        step();
        step();
        rst = 1'b0;
        instr_ready = 1'b1;
        imem_gnt = 1'b1;
        expectPc(32'h0);
        expectPc(32'h4);
        atNeg();
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, RESET_PC);
        step();
        step();
        imem_gnt = 1'b0;
        drain("restart", 5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
